// File: rtl/di_table_loader_pkg.sv
// Shared types for the DI table loader: FSM encodings, error codes,
// well-known terminal addresses and the latched transfer configuration.
// Optional feature macro: DI_TABLE_VERIFY_EN (read-back verify phase).
package di_table_loader_pkg;

  localparam int unsigned TERM_ADDR_W = 16;
  localparam int unsigned REG_ADDR_W  = 32;
  localparam int unsigned STATUS_W    = 16;
  localparam int unsigned ERR_CODE_W  = 2;

  // Terminal addresses of the DI responders that hold loadable tables
  localparam logic [TERM_ADDR_W-1:0] TERM_GAMMA_LOOKUP  = 16'h0040;
  localparam logic [TERM_ADDR_W-1:0] TERM_DEGAMMA       = 16'h0041;
  localparam logic [TERM_ADDR_W-1:0] TERM_COLOR_MATRIX  = 16'h0050;
  localparam logic [TERM_ADDR_W-1:0] TERM_DITHER_TABLE  = 16'h0060;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SETUP     = 3'd1,
    ST_WRITE     = 3'd2,
    ST_REWIND    = 3'd3,
    ST_READ_REQ  = 3'd4,
    ST_READ_WAIT = 3'd5,
    ST_DONE      = 3'd6,
    ST_ERROR     = 3'd7
  } state_e;

  typedef enum logic [ERR_CODE_W-1:0] {
    ERR_NONE    = 2'd0,
    ERR_TIMEOUT = 2'd1,
    ERR_STATUS  = 2'd2,
    ERR_VERIFY  = 2'd3
  } err_code_e;

  // Configuration captured when a transfer is accepted
  typedef struct packed {
    logic [TERM_ADDR_W-1:0] term_addr;
    logic [REG_ADDR_W-1:0]  base_addr;
  } xfer_cfg_t;

  // Register address of word 'idx' of a table; wraps modulo 2**32
  function automatic logic [REG_ADDR_W-1:0] table_addr(
    input logic [REG_ADDR_W-1:0] base,
    input logic [REG_ADDR_W-1:0] idx
  );
    return base + idx;
  endfunction

endpackage

// File: rtl/di_table_loader_wait_timer.sv
// di_wait_timer: loadable down-counter bounding every wait on the DI
// responder. Reloaded on each claim/beat; expired once the full budget of
// enabled cycles has elapsed without a reload.
module di_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic if_clk,
  input  logic resetb,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: reload wins over countdown; saturate at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CW'(TIMEOUT_CYCLES);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Counter register
  always_ff @(posedge if_clk or negedge resetb) begin
    if (!resetb) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i & (cnt_q == '0);

endmodule

// File: rtl/di_table_loader.sv
// di_table_loader: DI-bus initiator streaming a table from an upstream
// source into sequential registers of one DI terminal, with done/error
// reporting. Define DI_TABLE_VERIFY_EN to add a read-back verify phase;
// without it the read outputs and src_rewind are tied low.
module di_table_loader
  import di_table_loader_pkg::*;
#(
  parameter int unsigned DI_DATA_WIDTH  = 16,
  parameter int unsigned CNT_WIDTH      = 11,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                     if_clk,
  input  logic                     resetb,
  input  logic                     start,
  input  logic [TERM_ADDR_W-1:0]   cfg_term_addr,
  input  logic [REG_ADDR_W-1:0]    cfg_base_addr,
  input  logic [CNT_WIDTH-1:0]     cfg_count,
  input  logic                     src_valid,
  input  logic [DI_DATA_WIDTH-1:0] src_data,
  output logic                     src_ready,
  output logic                     src_rewind,
  output logic [TERM_ADDR_W-1:0]   di_term_addr,
  output logic [REG_ADDR_W-1:0]    di_reg_addr,
  output logic                     di_write_mode,
  output logic                     di_write,
  output logic [DI_DATA_WIDTH-1:0] di_reg_datai,
  output logic                     di_read_mode,
  output logic                     di_read_req,
  output logic                     di_read,
  input  logic                     di_write_rdy,
  input  logic                     di_read_rdy,
  input  logic [DI_DATA_WIDTH-1:0] di_reg_datao,
  input  logic [STATUS_W-1:0]      di_transfer_status,
  input  logic                     di_en,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [ERR_CODE_W-1:0]    err_code
);

  state_e                  state_q, state_d;
  xfer_cfg_t               cfg_q, cfg_d;
  logic [CNT_WIDTH-1:0]    count_q, count_d;
  logic [CNT_WIDTH-1:0]    idx_q, idx_d;
  logic [TERM_ADDR_W-1:0]  term_addr_q, term_addr_d;
  logic [REG_ADDR_W-1:0]   reg_addr_q, reg_addr_d;
  logic                    write_mode_q, write_mode_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;
  err_code_e               err_code_q, err_code_d;

  logic                    wr_phase;
  logic                    wr_beat;
  logic                    tmr_load;
  logic                    tmr_en;
  logic                    tmr_expired;
  logic                    err_go;
  err_code_e               err_sel;
  logic [CNT_WIDTH-1:0]    idx_inc;
  logic [REG_ADDR_W-1:0]   addr_next;
  logic                    last_word;

`ifdef DI_TABLE_VERIFY_EN
  logic                    read_mode_q, read_mode_d;
  logic                    read_req_q, read_req_d;
  logic                    rewind_q, rewind_d;
  logic                    rd_phase;
  logic                    rd_beat;
  logic                    rd_match;
`else
  logic                    unused_read_c;
`endif

  // Beat index bookkeeping shared by the write and read phases
  assign idx_inc   = idx_q + CNT_WIDTH'(1);
  assign addr_next = table_addr(cfg_q.base_addr, REG_ADDR_W'(idx_inc));
  assign last_word = (idx_inc == count_q);

  // Write-phase handshake is combinational so a beat costs one cycle
  assign wr_phase     = (state_q == ST_WRITE);
  assign di_write     = wr_phase & src_valid;
  assign wr_beat      = di_write & di_write_rdy;
  assign di_reg_datai = di_write ? src_data : '0;

`ifdef DI_TABLE_VERIFY_EN
  // Read-back: a word is consumed once both responder and source present it
  assign rd_phase   = (state_q == ST_READ_WAIT);
  assign rd_beat    = rd_phase & di_read_rdy & src_valid;
  assign rd_match   = (di_reg_datao == src_data);
  assign di_read    = rd_beat & rd_match;
  assign src_ready  = wr_beat | rd_beat;
  assign tmr_en     = (state_q == ST_SETUP) | wr_phase | rd_phase;
  assign di_read_mode = read_mode_q;
  assign di_read_req  = read_req_q;
  assign src_rewind   = rewind_q;
`else
  assign src_ready    = wr_beat;
  assign tmr_en       = (state_q == ST_SETUP) | wr_phase;
  assign di_read      = 1'b0;
  assign di_read_mode = 1'b0;
  assign di_read_req  = 1'b0;
  assign src_rewind   = 1'b0;
  assign unused_read_c = di_read_rdy ^ (^di_reg_datao);
`endif

  di_wait_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .if_clk    (if_clk),
    .resetb    (resetb),
    .load_i    (tmr_load),
    .en_i      (tmr_en),
    .expired_o (tmr_expired)
  );

  // Next-state and registered-output logic for the transfer sequencer
  always_comb begin
    state_d      = state_q;
    cfg_d        = cfg_q;
    count_d      = count_q;
    idx_d        = idx_q;
    term_addr_d  = term_addr_q;
    reg_addr_d   = reg_addr_q;
    write_mode_d = write_mode_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    error_d      = error_q;
    err_code_d   = err_code_q;
`ifdef DI_TABLE_VERIFY_EN
    read_mode_d  = read_mode_q;
    read_req_d   = 1'b0;
    rewind_d     = 1'b0;
`endif
    tmr_load     = 1'b0;
    err_go       = 1'b0;
    err_sel      = ERR_NONE;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cfg_d.term_addr = cfg_term_addr;
          cfg_d.base_addr = cfg_base_addr;
          count_d         = cfg_count;
          idx_d           = '0;
          error_d         = 1'b0;
          err_code_d      = ERR_NONE;
          busy_d          = 1'b1;
          if (cfg_count == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d      = ST_SETUP;
            term_addr_d  = cfg_term_addr;
            reg_addr_d   = cfg_base_addr;
            write_mode_d = 1'b1;
            tmr_load     = 1'b1;
          end
        end
      end

      ST_SETUP: begin
        if (di_transfer_status != '0) begin
          err_go  = 1'b1;
          err_sel = ERR_STATUS;
        end else if (di_en && di_write_rdy) begin
          state_d  = ST_WRITE;
          tmr_load = 1'b1;
        end else if (tmr_expired) begin
          err_go  = 1'b1;
          err_sel = ERR_TIMEOUT;
        end
      end

      ST_WRITE: begin
        if (wr_beat) begin
          idx_d      = idx_inc;
          reg_addr_d = addr_next;
          tmr_load   = 1'b1;
          if (last_word) begin
            write_mode_d = 1'b0;
`ifdef DI_TABLE_VERIFY_EN
            state_d     = ST_REWIND;
            rewind_d    = 1'b1;
            read_mode_d = 1'b1;
            idx_d       = '0;
            reg_addr_d  = cfg_q.base_addr;
`else
            state_d     = ST_DONE;
            done_d      = 1'b1;
            term_addr_d = '0;
            reg_addr_d  = '0;
`endif
          end
        end else if (tmr_expired) begin
          err_go  = 1'b1;
          err_sel = ERR_TIMEOUT;
        end
      end

`ifdef DI_TABLE_VERIFY_EN
      ST_REWIND: begin
        state_d    = ST_READ_REQ;
        read_req_d = 1'b1;
        tmr_load   = 1'b1;
      end

      ST_READ_REQ: begin
        state_d = ST_READ_WAIT;
      end

      ST_READ_WAIT: begin
        if (rd_beat) begin
          if (!rd_match) begin
            err_go  = 1'b1;
            err_sel = ERR_VERIFY;
          end else if (last_word) begin
            state_d     = ST_DONE;
            done_d      = 1'b1;
            read_mode_d = 1'b0;
            term_addr_d = '0;
            reg_addr_d  = '0;
          end else begin
            state_d    = ST_READ_REQ;
            read_req_d = 1'b1;
            idx_d      = idx_inc;
            reg_addr_d = addr_next;
            tmr_load   = 1'b1;
          end
        end else if (tmr_expired) begin
          err_go  = 1'b1;
          err_sel = ERR_TIMEOUT;
        end
      end
`endif

      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      ST_ERROR: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort: idle the bus, flag the cause and pulse done on entry
    if (err_go) begin
      state_d      = ST_ERROR;
      done_d       = 1'b1;
      error_d      = 1'b1;
      err_code_d   = err_sel;
      term_addr_d  = '0;
      reg_addr_d   = '0;
      write_mode_d = 1'b0;
`ifdef DI_TABLE_VERIFY_EN
      read_mode_d  = 1'b0;
      read_req_d   = 1'b0;
`endif
    end
  end

  // State and output registers
  always_ff @(posedge if_clk or negedge resetb) begin
    if (!resetb) begin
      state_q      <= ST_IDLE;
      cfg_q        <= '0;
      count_q      <= '0;
      idx_q        <= '0;
      term_addr_q  <= '0;
      reg_addr_q   <= '0;
      write_mode_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      err_code_q   <= ERR_NONE;
`ifdef DI_TABLE_VERIFY_EN
      read_mode_q  <= 1'b0;
      read_req_q   <= 1'b0;
      rewind_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cfg_q        <= cfg_d;
      count_q      <= count_d;
      idx_q        <= idx_d;
      term_addr_q  <= term_addr_d;
      reg_addr_q   <= reg_addr_d;
      write_mode_q <= write_mode_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      err_code_q   <= err_code_d;
`ifdef DI_TABLE_VERIFY_EN
      read_mode_q  <= read_mode_d;
      read_req_q   <= read_req_d;
      rewind_q     <= rewind_d;
`endif
    end
  end

  assign di_term_addr  = term_addr_q;
  assign di_reg_addr   = reg_addr_q;
  assign di_write_mode = write_mode_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign err_code      = err_code_q;

endmodule

// File: tb/tb_di_table_loader.sv
// Directed/randomized bench for di_table_loader: a source queue, a DI
// responder with a backing memory and an ideal table model.
module tb_di_table_loader;
  import di_table_loader_pkg::*;

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 11;
  localparam int unsigned TO = 1024;

  logic                   if_clk = 1'b0;
  logic                   resetb;
  logic                   start;
  logic [15:0]            cfg_term_addr;
  logic [31:0]            cfg_base_addr;
  logic [CW-1:0]          cfg_count;
  logic                   src_valid;
  logic [DW-1:0]          src_data;
  logic                   src_ready, src_rewind;
  logic [15:0]            di_term_addr;
  logic [31:0]            di_reg_addr;
  logic                   di_write_mode, di_write;
  logic [DW-1:0]          di_reg_datai;
  logic                   di_read_mode, di_read_req, di_read;
  logic                   di_write_rdy, di_read_rdy;
  logic [DW-1:0]          di_reg_datao;
  logic [15:0]            di_transfer_status;
  logic                   di_en;
  logic                   busy, done, error;
  logic [1:0]             err_code;

  di_table_loader #(.DI_DATA_WIDTH(DW), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)) dut (
    .if_clk(if_clk), .resetb(resetb), .start(start),
    .cfg_term_addr(cfg_term_addr), .cfg_base_addr(cfg_base_addr), .cfg_count(cfg_count),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready), .src_rewind(src_rewind),
    .di_term_addr(di_term_addr), .di_reg_addr(di_reg_addr), .di_write_mode(di_write_mode),
    .di_write(di_write), .di_reg_datai(di_reg_datai), .di_read_mode(di_read_mode),
    .di_read_req(di_read_req), .di_read(di_read), .di_write_rdy(di_write_rdy),
    .di_read_rdy(di_read_rdy), .di_reg_datao(di_reg_datao),
    .di_transfer_status(di_transfer_status), .di_en(di_en),
    .busy(busy), .done(done), .error(error), .err_code(err_code)
  );

  always #5 if_clk = ~if_clk;

  int checks   = 0;
  int failures = 0;

  // Stimulus knobs
  int rdy_toggle, gap_pct, en_never, status_err, corrupt_word, reset_at_beat, restart_at;

  // Source contents, responder memory and observations of one transfer
  logic [DW-1:0] words[$];
  logic [DW-1:0] mem [logic [31:0]];
  logic [31:0]   beat_addr[$];
  logic [DW-1:0] beat_data[$];
  int ptr, wr_strobes, bad_mode, bad_term, reads, req_cnt, rewinds, rmode_cycles;
  int last_wbeat, last_read, done_at;
  bit done_seen, aborted, rd_pending, busy_after, done_after, err_at_done;
  logic [1:0]  code_at_done;
  logic [31:0] rd_addr;
  int rd_delay;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] all_outputs();
    return 128'({src_ready, src_rewind, di_term_addr, di_reg_addr, di_write_mode, di_write,
                 di_reg_datai, di_read_mode, di_read_req, di_read, busy, done, error, err_code});
  endfunction

  task automatic idle_inputs();
    start = 1'b0; src_valid = 1'b0; src_data = '0; di_write_rdy = 1'b0; di_read_rdy = 1'b0;
    di_reg_datao = '0; di_transfer_status = '0; di_en = 1'b0;
  endtask

  task automatic set_knobs(input int tog, input int gap, input int enn, input int st,
                           input int corr, input int rst_beat, input int rs);
    rdy_toggle = tog; gap_pct = gap; en_never = enn; status_err = st;
    corrupt_word = corr; reset_at_beat = rst_beat; restart_at = rs;
  endtask

  // One transfer: drive source and responder, record everything the DUT does
  task automatic run_xfer(input logic [15:0] term, input logic [31:0] base, input int count,
                          input int budget);
    int n;
    words.delete(); mem.delete(); beat_addr.delete(); beat_data.delete();
    for (int i = 0; i < count; i++) words.push_back(DW'($urandom));
    ptr = 0; wr_strobes = 0; bad_mode = 0; bad_term = 0; reads = 0; req_cnt = 0;
    rewinds = 0; rmode_cycles = 0; last_wbeat = -1; last_read = -1; done_at = -1;
    done_seen = 0; aborted = 0; rd_pending = 0; rd_delay = 0; rd_addr = '0;
    @(posedge if_clk); #1;
    idle_inputs();
    start = 1'b1; cfg_term_addr = term; cfg_base_addr = base; cfg_count = CW'(count);
    @(posedge if_clk); #1;
    start = 1'b0;
    n = 0;
    while (n <= budget) begin
      di_en = (en_never == 0);
      di_write_rdy = (rdy_toggle == 0) || (n % 2 == 0);
      di_transfer_status = (status_err != 0) ? 16'hffff : 16'h0000;
      if (ptr < words.size() && $urandom_range(99) >= gap_pct) begin
        src_valid = 1'b1; src_data = words[ptr];
      end else begin
        src_valid = 1'b0; src_data = DW'($urandom);
      end
      if (rd_pending && rd_delay == 0) begin
        di_read_rdy = 1'b1;
        di_reg_datao = mem[rd_addr] ^ ((int'(rd_addr - base) == corrupt_word) ? 16'h8000 : 16'h0000);
      end else begin
        di_read_rdy = 1'b0; di_reg_datao = DW'($urandom);
        if (rd_pending) rd_delay--;
      end
      start = (n == restart_at);
      cfg_base_addr = start ? 32'hdead_0000 : base;
      cfg_count = start ? CW'(2) : CW'(count);
      @(negedge if_clk);
      if (di_write) wr_strobes++;
      if (di_write && !di_write_mode) bad_mode++;
      if (di_read_mode) rmode_cycles++;
      if (di_write_mode && src_ready) begin
        beat_addr.push_back(di_reg_addr); beat_data.push_back(di_reg_datai);
        if (di_term_addr !== term) bad_term++;
        mem[di_reg_addr] = di_reg_datai; ptr++; last_wbeat = n;
      end
      if (di_read_mode && src_ready) begin
        ptr++; rd_pending = 0;
        if (di_read) begin reads++; last_read = n; end
      end
      if (di_read_req) begin
        req_cnt++; rd_pending = 1; rd_addr = di_reg_addr; rd_delay = $urandom_range(0, 2);
      end
      if (src_rewind) begin rewinds++; ptr = 0; end
      if (done) begin
        done_seen = 1; done_at = n; err_at_done = error; code_at_done = err_code;
      end
      if (reset_at_beat > 0 && beat_addr.size() == reset_at_beat && !done_seen) begin
        resetb = 1'b0; #1;
        check("async_reset_outputs", all_outputs(), 128'd0);
        aborted = 1;
      end
      if (done_seen || aborted) break;
      @(posedge if_clk); #1;
      n++;
    end
    check("xfer_finished", 128'(done_seen | aborted), 128'd1);
    if (!aborted) begin
      @(posedge if_clk); #1;
      busy_after = busy; done_after = done;
    end
    idle_inputs();
  endtask

  // Compare recorded write beats against the ideal table placement
  task automatic check_writes(input string tag, input logic [31:0] base, input int count);
    check({tag, "_nbeats"}, 128'(beat_addr.size()), 128'(count));
    for (int i = 0; i < count && i < beat_addr.size(); i++) begin
      logic [31:0] ea;
      ea = base + 32'(i);
      check($sformatf("%s_addr%0d", tag, i), 128'(beat_addr[i]), 128'(ea));
      check($sformatf("%s_data%0d", tag, i), 128'(beat_data[i]), 128'(words[i]));
    end
    check({tag, "_term_held"}, 128'(bad_term), 128'd0);
    check({tag, "_write_outside_mode"}, 128'(bad_mode), 128'd0);
  endtask

  // Clean completion: pulse width, status, optional read-back accounting
  task automatic check_ok(input string tag, input int count);
    check({tag, "_error"}, 128'({err_at_done, code_at_done}), 128'd0);
    check({tag, "_done_1cyc"}, 128'({busy_after, done_after}), 128'd0);
`ifdef DI_TABLE_VERIFY_EN
    check({tag, "_rewinds"}, 128'(rewinds), 128'(count > 0 ? 1 : 0));
    check({tag, "_reads"}, 128'(reads), 128'(count));
    check({tag, "_read_reqs"}, 128'(req_cnt), 128'(count));
    if (count > 0) check({tag, "_done_after_last_read"}, 128'(done_at), 128'(last_read + 1));
`else
    check({tag, "_no_read_activity"}, 128'(rewinds + reads + req_cnt + rmode_cycles), 128'd0);
    if (count > 0) check({tag, "_done_after_last_beat"}, 128'(done_at), 128'(last_wbeat + 1));
`endif
  endtask

  initial begin
    resetb = 1'b0;
    idle_inputs();
    cfg_term_addr = '0; cfg_base_addr = '0; cfg_count = '0;
    set_knobs(0, 0, 0, 0, -1, 0, -1);
    repeat (3) @(posedge if_clk);
    #1;
    check("reset_state", all_outputs(), 128'd0);
    @(negedge if_clk); resetb = 1'b1;

    // Back-to-back source, always-ready responder
    set_knobs(0, 0, 0, 0, -1, 0, -1);
    run_xfer(TERM_GAMMA_LOOKUP, 32'h0000_0010, 4, 200);
    check_writes("t1", 32'h10, 4);
    check_ok("t1", 4);

    // Ready toggling, source gaps, ignored start while busy
    set_knobs(1, 35, 0, 0, -1, 0, 3);
    run_xfer(TERM_COLOR_MATRIX, 32'h0000_1200, 8, 400);
    check_writes("t2", 32'h1200, 8);
    check_ok("t2", 8);

    // Terminal never claimed: timeout
    set_knobs(0, 0, 1, 0, -1, 0, -1);
    run_xfer(TERM_DEGAMMA, 32'h0000_0100, 5, TO + 20);
    check("t3_err", 128'({err_at_done, code_at_done}), 128'({1'b1, 2'd1}));
    check("t3_when", 128'(done_at), 128'(TO + 1));
    check("t3_no_write", 128'(wr_strobes), 128'd0);
    check("t3_done_1cyc", 128'({busy_after, done_after}), 128'd0);
    repeat (4) @(posedge if_clk);
    #1;
    check("t3_error_sticky", 128'({error, err_code}), 128'({1'b1, 2'd1}));

    // Terminal status error during setup
    set_knobs(0, 0, 0, 1, -1, 0, -1);
    run_xfer(TERM_DITHER_TABLE, 32'h0000_0200, 3, 50);
    check("t4_err", 128'({err_at_done, code_at_done}), 128'({1'b1, 2'd2}));
    check("t4_when", 128'(done_at), 128'd1);
    check("t4_no_write", 128'(wr_strobes), 128'd0);

    // Zero-length table: immediate done, previous error cleared
    set_knobs(0, 0, 0, 0, -1, 0, -1);
    run_xfer(TERM_GAMMA_LOOKUP, 32'h0000_0300, 0, 20);
    check("t5_when", 128'(done_at), 128'd0);
    check("t5_nbeats", 128'(beat_addr.size()), 128'd0);
    check_ok("t5", 0);

    // Register address wraps past 2**32
    set_knobs(1, 20, 0, 0, -1, 0, -1);
    run_xfer(TERM_GAMMA_LOOKUP, 32'hffff_fffe, 4, 200);
    check_writes("t6", 32'hffff_fffe, 4);
    check_ok("t6", 4);

    // Reset on the third write beat, then a fresh transfer
    set_knobs(0, 0, 0, 0, -1, 3, -1);
    run_xfer(TERM_GAMMA_LOOKUP, 32'h0000_0400, 6, 200);
    check("t7_aborted", 128'(aborted), 128'd1);
    repeat (2) @(posedge if_clk);
    @(negedge if_clk); resetb = 1'b1;
    set_knobs(0, 10, 0, 0, -1, 0, -1);
    run_xfer(TERM_GAMMA_LOOKUP, 32'h0000_0500, 5, 200);
    check_writes("t7b", 32'h500, 5);
    check_ok("t7b", 5);

`ifdef DI_TABLE_VERIFY_EN
    // Read-back returns word 2 corrupted
    set_knobs(0, 0, 0, 0, 2, 0, -1);
    run_xfer(TERM_GAMMA_LOOKUP, 32'h0000_0600, 6, 300);
    check_writes("t8", 32'h600, 6);
    check("t8_err", 128'({err_at_done, code_at_done}), 128'({1'b1, 2'd3}));
    check("t8_read_reqs", 128'(req_cnt), 128'd3);
    check("t8_reads", 128'(reads), 128'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
